vc_opctrl: RTL and testbench
============================

VC_OPCTRL -- requirements
Module: vc_opctrl

Interface
REQ-001 Parameter DATA_W, 64, flit width in bits.
REQ-002 Parameter NUM_IN, 5, number of input ports (index 0=pe, 1=s, 2=n, 3=e, 4=w at default).
REQ-003 Parameter DEPTH, 2, entries per virtual-channel FIFO; power of two, >=2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 polarity  input  1  current cycle parity; write VC = polarity, read VC = ~polarity.
REQ-007 grant  input  NUM_IN  one-hot arbiter grant selecting the source port.
REQ-008 data_in  input  NUM_IN*DATA_W  flattened input flits; port i at bits [i*DATA_W +: DATA_W].
REQ-009 receive_output  input  1  downstream ready.
REQ-010 data_out  output  DATA_W  registered outgoing flit.
REQ-011 send_output  output  1  registered valid for data_out.
REQ-012 clear  output  NUM_IN  combinational pop strobe to granted input buffer.
REQ-013 vc_empty  output  2  per-VC empty flag; bit 0 even, bit 1 odd.
REQ-014 vc_full  output  2  per-VC full flag.
REQ-015 empty  output  1  AND of vc_empty.

Function
REQ-016 Two independent FIFOs of DEPTH x DATA_W, indexed by VC; pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full when MSBs differ and LSBs equal.
REQ-017 Write accept = grant one-hot AND !vc_full[polarity]; on accept, data_in of granted port pushed into VC[polarity] at the clock edge.
REQ-018 clear = grant when write accepted, else all-zero; same cycle as grant, no latency.
REQ-019 grant all-zero or multi-hot: no write, clear = 0.
REQ-020 Read = receive_output AND !vc_empty[~polarity]; on read, head of VC[~polarity] registered into data_out, send_output=1 next cycle, entry popped.
REQ-021 No read: send_output=0 next cycle; data_out holds last value.
REQ-022 Write and read in one cycle target different VCs; both proceed independently.
REQ-023 Write to a full VC: dropped, clear=0, FIFO unchanged.
REQ-024 vc_empty, vc_full, empty derived from pointers, reflecting state after the last edge.
REQ-025 Latency: flit written at cycle N (polarity p) is eligible for read at the first later cycle with polarity ~p; appears on data_out one cycle after that read.

Reset
REQ-026 reset=1 at a clock edge: pointers cleared, data_out=0, send_output=0, vc_empty=2'b11, vc_full=2'b00, empty=1.
REQ-027 Reset overrides any write or read in the same cycle; FIFO contents discarded mid-operation.
REQ-028 clear forced to 0 while reset=1.

Configuration
REQ-029 Macro VC_OPCTRL_ERR_EN defined: extra output grant_err (1 bit, registered, reset 0) pulses 1 for one cycle after any cycle with multi-hot grant or grant to a full VC.
REQ-030 VC_OPCTRL_ERR_EN undefined: grant_err port absent; such cycles silently ignored per REQ-019/REQ-023.

Verification
REQ-031 Reset held 1 cycle -> data_out=0, send_output=0, empty=1, vc_empty=2'b11.
REQ-032 polarity=0, grant=5'b00001, data_in pe=AAAA_AAAA_AAAA_AAAA, receive_output=1; next cycle polarity=1 -> clear=5'b00001 first cycle; data_out=AAAA_AAAA_AAAA_AAAA, send_output=1 one cycle after read.
REQ-033 polarity=1, grant=5'b00010 (s=BBBB...) then 5'b00100 (n=CCCC...) with receive_output=0 -> vc_full[1]=1; third grant 5'b01000 -> clear=0, FIFO unchanged; later reads give BBBB... then CCCC... in order.
REQ-034 Alternating polarity, grant=5'b01000 (DDDD...) each cycle, receive_output=1 -> simultaneous write/read, send_output=1 every cycle after 2-cycle fill, no loss.
REQ-035 grant=5'b00110 -> clear=0, no write; with VC_OPCTRL_ERR_EN, grant_err=1 next cycle.
REQ-036 Reset asserted with both VCs non-empty -> vc_empty=2'b11, send_output=0 next cycle.

Source files
------------

// File: rtl/vc_opctrl_if.sv
// Bundle of the arbitration, flit and status signals of the VC output controller.
// Optional grant_err appears when VC_OPCTRL_ERR_EN is defined.
interface vc_opctrl_if #(
   parameter int DATA_W = 64,
   parameter int NUM_IN = 5
);
   logic                     polarity;
   logic [NUM_IN-1:0]        grant;
   logic [NUM_IN*DATA_W-1:0] data_in;
   logic                     receive_output;
   logic [DATA_W-1:0]        data_out;
   logic                     send_output;
   logic [NUM_IN-1:0]        clear;
   logic [1:0]               vc_empty;
   logic [1:0]               vc_full;
   logic                     empty;
`ifdef VC_OPCTRL_ERR_EN
   logic                     grant_err;

   modport master (
      output polarity, grant, data_in, receive_output,
      input  data_out, send_output, clear, vc_empty, vc_full, empty, grant_err
   );
   modport slave (
      input  polarity, grant, data_in, receive_output,
      output data_out, send_output, clear, vc_empty, vc_full, empty, grant_err
   );
`else
   modport master (
      output polarity, grant, data_in, receive_output,
      input  data_out, send_output, clear, vc_empty, vc_full, empty
   );
   modport slave (
      input  polarity, grant, data_in, receive_output,
      output data_out, send_output, clear, vc_empty, vc_full, empty
   );
`endif
endinterface

// File: rtl/vc_opctrl.sv
// Two-VC output controller: the granted input flit is pushed into VC[polarity] while VC[~polarity] drains downstream.
// Define VC_OPCTRL_ERR_EN to add the registered grant_err flag for multi-hot grants and grants to a full VC.
module vc_opctrl #(
   parameter int DATA_W = 64,
   parameter int NUM_IN = 5,
   parameter int DEPTH  = 2
) (
   input logic        clk,
   input logic        reset,
   vc_opctrl_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic                   grant_onehot;
   logic                   write_accept;
   logic                   read_accept;
   logic                   rd_vc;
   logic [DATA_W-1:0]      wr_data;
   logic [1:0]             vc_empty_w;
   logic [1:0]             vc_full_w;
   logic [1:0][DATA_W-1:0] head;
   logic [DATA_W-1:0]      data_out_reg;
   logic                   send_output_reg;

   assign grant_onehot = (bus.grant != '0) && ((bus.grant & (bus.grant - 1'b1)) == '0);
   assign rd_vc        = ~bus.polarity;
   assign write_accept = !reset && grant_onehot && !vc_full_w[bus.polarity];
   assign read_accept  = !reset && bus.receive_output && !vc_empty_w[rd_vc];

   // Grant is one-hot whenever the write is accepted, so an OR of masked ports is a plain mux.
   always_comb begin
      wr_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (bus.grant[i]) wr_data = wr_data | bus.data_in[i*DATA_W +: DATA_W];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_vc
         logic [DATA_W-1:0] mem_reg [DEPTH];
         logic [PTR_W-1:0]  wr_ptr_reg;
         logic [PTR_W-1:0]  rd_ptr_reg;
         logic              wr_en;
         logic              rd_en;

         assign wr_en = write_accept && (bus.polarity == 1'(gi));
         assign rd_en = read_accept && (rd_vc == 1'(gi));

         // Extra pointer MSB distinguishes a full FIFO from an empty one.
         assign vc_empty_w[gi] = (wr_ptr_reg == rd_ptr_reg);
         assign vc_full_w[gi]  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                                 (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
         assign head[gi]       = mem_reg[rd_ptr_reg[ADDR_W-1:0]];

         always_ff @(posedge clk) begin
            if (wr_en) mem_reg[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
            end else begin
               if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
               if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_reg    <= '0;
         send_output_reg <= 1'b0;
      end else begin
         send_output_reg <= read_accept;
         if (read_accept) data_out_reg <= head[rd_vc];
      end
   end

   assign bus.data_out    = data_out_reg;
   assign bus.send_output = send_output_reg;
   assign bus.clear       = write_accept ? bus.grant : '0;
   assign bus.vc_empty    = vc_empty_w;
   assign bus.vc_full     = vc_full_w;
   assign bus.empty       = &vc_empty_w;

`ifdef VC_OPCTRL_ERR_EN
   logic grant_err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_err_reg <= 1'b0;
      end else begin
         grant_err_reg <= ((bus.grant != '0) && !grant_onehot) ||
                          (grant_onehot && vc_full_w[bus.polarity]);
      end
   end

   assign bus.grant_err = grant_err_reg;
`endif
endmodule

// File: tb/tb_vc_opctrl.sv
// Bench for vc_opctrl: directed scenarios followed by random traffic, all checked against a queue-based model.
// Honours VC_OPCTRL_ERR_EN when the design is built with it.
module tb_vc_opctrl;
   localparam int DATA_W = 64;
   localparam int NUM_IN = 5;
   localparam int DEPTH  = 2;

   logic clk = 1'b0;
   logic reset;

   vc_opctrl_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) bus ();

   vc_opctrl #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int step_no = 0;
   bit primed = 1'b0;

   // Reference model: one queue per VC plus the expected registered outputs.
   logic [DATA_W-1:0] q_even [$];
   logic [DATA_W-1:0] q_odd  [$];
   logic [DATA_W-1:0] exp_dout = '0;
   logic              exp_send = 1'b0;
   logic              exp_err  = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", tag, step_no, got, exp);
      end
   endtask

   function automatic int q_size(input logic vc);
      return vc ? q_odd.size() : q_even.size();
   endfunction

   task automatic compare_outputs();
      logic [1:0] e_empty;
      logic [1:0] e_full;
      e_empty = {q_size(1'b1) == 0, q_size(1'b0) == 0};
      e_full  = {q_size(1'b1) == DEPTH, q_size(1'b0) == DEPTH};
      check_val("data_out", 64'(bus.data_out), 64'(exp_dout));
      check_val("send_output", 64'(bus.send_output), 64'(exp_send));
      check_val("vc_empty", 64'(bus.vc_empty), 64'(e_empty));
      check_val("vc_full", 64'(bus.vc_full), 64'(e_full));
      check_val("empty", 64'(bus.empty), 64'(&e_empty));
`ifdef VC_OPCTRL_ERR_EN
      check_val("grant_err", 64'(bus.grant_err), 64'(exp_err));
`endif
   endtask

   task automatic step(input logic pol, input logic [NUM_IN-1:0] gnt, input logic recv,
                       input logic rst, input logic [NUM_IN*DATA_W-1:0] din);
      logic              onehot;
      logic              wr_ok;
      logic              rd_ok;
      logic [DATA_W-1:0] wval;
      @(negedge clk);
      step_no++;
      if (primed) compare_outputs();
      reset              = rst;
      bus.polarity       = pol;
      bus.grant          = gnt;
      bus.receive_output = recv;
      bus.data_in        = din;
      #1;
      onehot = ($countones(gnt) == 1);
      wr_ok  = !rst && onehot && (q_size(pol) < DEPTH);
      rd_ok  = !rst && recv && (q_size(~pol) > 0);
      check_val("clear", 64'(bus.clear), 64'(wr_ok ? gnt : '0));
      $display("step %0d pol=%0b grant=%b recv=%0b rst=%0b clear=%b wr=%0b rd=%0b",
               step_no, pol, gnt, recv, rst, bus.clear, wr_ok, rd_ok);
      wval = '0;
      for (int i = 0; i < NUM_IN; i++) if (gnt[i]) wval = din[i*DATA_W +: DATA_W];
      if (rst) begin
         q_even.delete();
         q_odd.delete();
         exp_dout = '0;
         exp_send = 1'b0;
         exp_err  = 1'b0;
      end else begin
         exp_err  = ((gnt != '0) && !onehot) || (onehot && (q_size(pol) == DEPTH));
         exp_send = rd_ok;
         if (rd_ok) exp_dout = pol ? q_even.pop_front() : q_odd.pop_front();
         if (wr_ok) begin
            if (pol) q_odd.push_back(wval);
            else     q_even.push_back(wval);
         end
      end
      primed = 1'b1;
   endtask

   logic [NUM_IN*DATA_W-1:0] pat;
   logic [NUM_IN*DATA_W-1:0] rnd;
   logic [3:0]               nib;
   logic [NUM_IN-1:0]        g;
   int                       r;

   initial begin
      reset = 1'b1;
      bus.polarity = 1'b0;
      bus.grant = '0;
      bus.receive_output = 1'b0;
      bus.data_in = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         nib = 4'(4'hA + i);
         pat[i*DATA_W +: DATA_W] = {16{nib}};
      end

      step(1'b0, 5'b00000, 1'b0, 1'b1, pat);
      // Single flit written on even, read on odd.
      step(1'b0, 5'b00001, 1'b1, 1'b0, pat);
      step(1'b1, 5'b00000, 1'b1, 1'b0, pat);
      step(1'b0, 5'b00000, 1'b1, 1'b0, pat);
      // Fill odd VC, third grant dropped, then drain in order.
      step(1'b1, 5'b00010, 1'b0, 1'b0, pat);
      step(1'b1, 5'b00100, 1'b0, 1'b0, pat);
      step(1'b1, 5'b01000, 1'b0, 1'b0, pat);
      step(1'b0, 5'b00000, 1'b1, 1'b0, pat);
      step(1'b0, 5'b00000, 1'b1, 1'b0, pat);
      step(1'b0, 5'b00000, 1'b1, 1'b0, pat);
      // Streaming with alternating polarity.
      for (int k = 0; k < 8; k++) step(1'(k), 5'b01000, 1'b1, 1'b0, pat);
      // Multi-hot grant.
      step(1'b0, 5'b00110, 1'b1, 1'b0, pat);
      // Reset with both VCs occupied.
      step(1'b0, 5'b00001, 1'b0, 1'b0, pat);
      step(1'b1, 5'b00010, 1'b0, 1'b0, pat);
      step(1'b0, 5'b00000, 1'b1, 1'b1, pat);
      step(1'b1, 5'b00000, 1'b1, 1'b0, pat);

      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < NUM_IN; i++) rnd[i*DATA_W +: DATA_W] = {$urandom, $urandom};
         r = $urandom_range(0, 9);
         if (r < 6)      g = NUM_IN'(1) << $urandom_range(0, NUM_IN - 1);
         else if (r < 8) g = '0;
         else            g = NUM_IN'($urandom);
         step(1'($urandom), g, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, rnd);
      end

      @(negedge clk);
      step_no++;
      compare_outputs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
